dram_output_capture: RTL and testbench

Synthesizable capture stage between the processor's data-memory write bus and the output-image sink. Snoops every store, accepts only stores to the output mailbox address, buffers the pixels in a FIFO and presents them on a valid/ready stream to the downstream sink, which is the file writer in simulation or a host port on hardware. Also counts the pixels of one downsampled image and flags completion.

---
 rtl/downsample_pkg.sv | 17 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/dram_output_capture.sv | 114 +++++++++++
 tb/tb_dram_output_capture.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/downsample_pkg.sv
// Shared types and defaults for the downsample image pipeline.
// Holds the output-capture FSM state type and mailbox/image size defaults.
// Contains no logic.
package downsample_pkg;

   // Output-capture life cycle: waiting, filling, draining, finished.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int OUT_ADDR_DEF   = 80;      // data-memory mailbox address
   localparam int IMG_PIXELS_DEF = 16384;   // 128x128 output image

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, DEPTH x DATA_W, first-word-fall-through head.
// Latency: a push into an empty FIFO is visible on pop_data the next cycle.
// Backpressure: push when full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (level == (PTR_W+1)'(DEPTH));
   assign empty   = (level == '0);
   // A full FIFO may still take a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Drive zero when empty so the head is well defined out of reset.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Storage array; no reset needed, occupancy tracks validity.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (PTR_W+1)'(1);
            2'b01:   level <= level - (PTR_W+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dram_output_capture.sv
// Snoops data-memory stores, captures mailbox writes into a FIFO, streams pixels out.
// Latency: one cycle from an accepted store into an empty FIFO to out_valid.
// Backpressure: out_ready stalls the head; a full FIFO drops stores and sets overflow.
// Optional: define OUTCAP_CHECKSUM_EN to build the running 16-bit pixel checksum.
module dram_output_capture
   import downsample_pkg::*;
#(
   parameter int OUT_ADDR   = OUT_ADDR_DEF,
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 16,
   parameter int IMG_PIXELS = IMG_PIXELS_DEF,
   parameter int CNT_W      = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wren,
   input  logic [ADDR_W-1:0]        IRAM_address,
   input  logic [DATA_W-1:0]        data,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     out_ready,
   output logic [CNT_W-1:0]         pixel_count,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic                     done,
   output logic [15:0]              checksum
);

   state_t           state;
   state_t           state_nxt;
   logic             hit;
   logic             open;
   logic             pop;
   logic             full;
   logic             empty;
   logic             accept;
   logic             drop;
   logic             last;
   logic [CNT_W-1:0] cnt_inc;

   // Mailbox decode; only stores while the image is still open are taken.
   assign hit    = wren && (IRAM_address == ADDR_W'(OUT_ADDR));
   assign open   = (state == IDLE) || (state == CAPTURE);
   assign pop    = out_valid && out_ready;
   assign accept = hit && open && (!full || pop);
   assign drop   = hit && !accept;

   // Saturating next count; also tells the FSM this capture closes the image.
   assign cnt_inc = (pixel_count == '1) ? pixel_count : pixel_count + CNT_W'(1);
   assign last    = (32'(cnt_inc) == IMG_PIXELS);

   assign out_valid = !empty;
   assign done      = (state == DONE);

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (accept),
      .push_data (data),
      .pop       (pop),
      .pop_data  (out_data),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state: close on the IMG_PIXELS-th capture, finish once drained.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = last ? DRAIN : CAPTURE;
         CAPTURE: if (accept && last) state_nxt = DRAIN;
         DRAIN:   if (fifo_level == '0) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Accepted-pixel counter and sticky drop flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pixel_count <= '0;
         overflow    <= 1'b0;
      end else begin
         if (accept) pixel_count <= cnt_inc;
         if (drop)   overflow    <= 1'b1;
      end
   end

`ifdef OUTCAP_CHECKSUM_EN
   logic [15:0] sum_q;

   // Wrapping sum of every accepted pixel.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)      sum_q <= '0;
      else if (accept) sum_q <= sum_q + 16'(data);
   end

   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_dram_output_capture.sv
// Scoreboard bench: two DUTs (full-size image and a 4-pixel image) on shared stimulus.
// An abstract reference model predicts pixels and status; a negedge monitor compares.
// Directed phases follow the test plan, then a randomized phase with random resets.
module tb_dram_output_capture;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        wren = 1'b0;
   logic [7:0]  IRAM_address = '0;
   logic [7:0]  data = '0;
   logic        out_ready = 1'b0;

   logic [1:0]  vld;
   logic [7:0]  odat [2];
   logic [15:0] pcnt [2];
   logic [4:0]  flvl [2];
   logic [1:0]  ovf;
   logic [1:0]  dne;
   logic [15:0] csum [2];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state, per instance
   int          mlvl [2];
   int          mcnt [2];
   int          macc [2];
   int          msum [2];
   bit          movf [2];
   bit          mdone [2];
   int          npop [2];
   logic [7:0]  sb0 [$];
   logic [7:0]  sb1 [$];

`ifdef OUTCAP_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   always #5 clock = ~clock;

   dram_output_capture u_a (
      .clock(clock), .reset(reset), .wren(wren), .IRAM_address(IRAM_address), .data(data),
      .out_valid(vld[0]), .out_data(odat[0]), .out_ready(out_ready),
      .pixel_count(pcnt[0]), .fifo_level(flvl[0]), .overflow(ovf[0]), .done(dne[0]),
      .checksum(csum[0])
   );

   dram_output_capture #(.IMG_PIXELS(4)) u_b (
      .clock(clock), .reset(reset), .wren(wren), .IRAM_address(IRAM_address), .data(data),
      .out_valid(vld[1]), .out_data(odat[1]), .out_ready(out_ready),
      .pixel_count(pcnt[1]), .fifo_level(flvl[1]), .overflow(ovf[1]), .done(dne[1]),
      .checksum(csum[1])
   );

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s[%0d] @%0t: got %0d expected %0d", nm, idx, $time, act, exp);
      end
   endtask

   function automatic int sb_size(input int i);
      return (i == 0) ? sb0.size() : sb1.size();
   endfunction

   task automatic sb_push(input int i, input logic [7:0] d);
      if (i == 0) sb0.push_back(d);
      else        sb1.push_back(d);
   endtask

   task automatic sb_pop(input int i, output logic [7:0] d);
      if (i == 0) d = sb0.pop_front();
      else        d = sb1.pop_front();
   endtask

   function automatic logic [7:0] sb_front(input int i);
      return (i == 0) ? sb0[0] : sb1[0];
   endfunction

   // One clock of the specification rules, using pre-edge values.
   task automatic model_step(input int i);
      int img;
      bit pop, hit, closed, full;
      img    = (i == 0) ? 16384 : 4;
      pop    = (mlvl[i] > 0) && out_ready;
      hit    = wren && (IRAM_address == 8'd80);
      closed = (macc[i] >= img);
      full   = (mlvl[i] == 16);
      if (closed && mlvl[i] == 0) mdone[i] = 1'b1;
      if (pop) mlvl[i] = mlvl[i] - 1;
      if (hit) begin
         if (closed || (full && !pop)) begin
            movf[i] = 1'b1;
         end else begin
            sb_push(i, data);
            mlvl[i] = mlvl[i] + 1;
            macc[i] = macc[i] + 1;
            if (mcnt[i] < 65535) mcnt[i] = mcnt[i] + 1;
            msum[i] = (msum[i] + int'(data)) & 16'hFFFF;
         end
      end
   endtask

   // Reference model: cleared asynchronously with the DUT, stepped each edge.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            mlvl[i] = 0; mcnt[i] = 0; macc[i] = 0; msum[i] = 0;
            movf[i] = 1'b0; mdone[i] = 1'b0;
         end
         sb0.delete();
         sb1.delete();
      end else begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   // Monitor: compare outputs mid-cycle; retire the head when a transfer is due.
   always @(negedge clock) begin
      logic [7:0] d;
      for (int i = 0; i < 2; i++) begin
         chk("out_valid", i, int'(vld[i]), int'(mlvl[i] > 0));
         if (vld[i]) begin
            if (sb_size(i) == 0) begin
               chk("unexpected_pixel", i, 1, 0);
            end else begin
               chk("out_data", i, int'(odat[i]), int'(sb_front(i)));
               if (out_ready && reset) begin
                  sb_pop(i, d);
                  npop[i]++;
               end
            end
         end
         chk("pixel_count", i, int'(pcnt[i]), mcnt[i]);
         chk("fifo_level", i, int'(flvl[i]), mlvl[i]);
         chk("overflow", i, int'(ovf[i]), int'(movf[i]));
         chk("done", i, int'(dne[i]), int'(mdone[i]));
         chk("checksum", i, int'(csum[i]), CSUM_EN ? msum[i] : 0);
      end
   end

   // Drive one cycle's inputs, then move to just after the next edge.
   task automatic step(input bit w, input int a, input int d, input bit r);
      wren         = w;
      IRAM_address = a[7:0];
      data         = d[7:0];
      out_ready    = r;
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset();
      wren  = 1'b0;
      reset = 1'b0;
      @(posedge clock);
      #2;
      reset = 1'b1;
      @(posedge clock);
      #2;
   endtask

   initial begin
      int p0;
      npop[0] = 0;
      npop[1] = 0;
      #1;
      chk("rst_valid", 0, int'(vld[0]), 0);
      chk("rst_data", 0, int'(odat[0]), 0);
      chk("rst_level", 0, int'(flvl[0]), 0);
      @(posedge clock);
      #2;
      reset = 1'b1;
      @(posedge clock);
      #2;

      // basic capture
      step(1, 80, 'h11, 1);
      chk("lat_valid", 0, int'(vld[0]), 1);
      chk("lat_data", 0, int'(odat[0]), 'h11);
      step(1, 80, 'h22, 1);
      step(1, 80, 'h33, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("basic_count", 0, int'(pcnt[0]), 3);

      // address filter
      do_reset();
      step(1, 79, 'hAA, 1);
      step(1, 81, 'hAA, 1);
      step(0, 80, 'hAA, 1);
      step(0, 0, 0, 1);
      chk("filter_valid", 0, int'(vld[0]), 0);
      chk("filter_count", 0, int'(pcnt[0]), 0);

      // backpressure and overflow
      do_reset();
      for (int k = 0; k < 17; k++) step(1, 80, 'h40 + k, 0);
      step(0, 0, 0, 0);
      chk("bp_level", 0, int'(flvl[0]), 16);
      chk("bp_overflow", 0, int'(ovf[0]), 1);
      chk("bp_count", 0, int'(pcnt[0]), 16);
      p0 = npop[0];
      for (int k = 0; k < 20; k++) step(0, 0, 0, 1);
      chk("bp_drained", 0, npop[0] - p0, 16);
      chk("bp_empty", 0, int'(flvl[0]), 0);

      // full with simultaneous pop
      do_reset();
      for (int k = 0; k < 16; k++) step(1, 80, 'h80 + k, 0);
      step(1, 80, 'hC5, 1);
      chk("fullpop_level", 0, int'(flvl[0]), 16);
      chk("fullpop_overflow", 0, int'(ovf[0]), 0);
      for (int k = 0; k < 20; k++) step(0, 0, 0, 1);

      // completion on the 4-pixel instance
      do_reset();
      for (int k = 1; k <= 4; k++) step(1, 80, k, 1);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
      chk("cmp_done", 1, int'(dne[1]), 1);
      chk("cmp_ovf_before", 1, int'(ovf[1]), 0);
      step(1, 80, 5, 1);
      step(0, 0, 0, 1);
      chk("cmp_ovf", 1, int'(ovf[1]), 1);
      chk("cmp_done_held", 1, int'(dne[1]), 1);
      chk("cmp_empty", 1, int'(vld[1]), 0);
      if (CSUM_EN) chk("cmp_checksum", 1, int'(csum[1]), 10);

      // reset mid-stream
      do_reset();
      for (int k = 0; k < 5; k++) step(1, 80, 'h60 + k, 0);
      chk("mid_level", 0, int'(flvl[0]), 5);
      reset = 1'b0;
      #1;
      chk("mid_valid", 0, int'(vld[0]), 0);
      chk("mid_data", 0, int'(odat[0]), 0);
      chk("mid_level0", 0, int'(flvl[0]), 0);
      chk("mid_count", 0, int'(pcnt[0]), 0);
      chk("mid_done_b", 1, int'(dne[1]), 0);
      @(posedge clock);
      #2;
      reset = 1'b1;
      step(1, 80, 'h5A, 1);
      chk("post_valid", 0, int'(vld[0]), 1);
      chk("post_data", 0, int'(odat[0]), 'h5A);
      step(0, 0, 0, 1);

      // randomized traffic with occasional resets
      for (int k = 0; k < 1500; k++) begin
         int sel;
         int addr;
         sel = int'($urandom_range(0, 7));
         addr = (sel < 5) ? 80 : (sel == 5) ? 79 : (sel == 6) ? 81 : int'($urandom_range(0, 255));
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b0;
            step(0, 0, 0, 0);
            reset = 1'b1;
         end else begin
            step(($urandom_range(0, 3) != 0), addr, int'($urandom_range(0, 255)),
                 ((k / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
         end
      end
      for (int k = 0; k < 20; k++) step(0, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
